// File: rtl/vga_sync_800x600.sv
// -----------------------------------------------------------------------------
// vga_sync_800x600
//   Raster timing generator for an 800x600 display. It scans a pixel position
//   across the whole frame, including the blanking intervals, and produces the
//   sync pulses, a visible-area flag and a frame-start pulse. The default timing
//   is 800x600 with a 50 MHz pixel clock: 1040 clocks per line, 666 lines per
//   frame.
//
//   Ports
//     clk        in   pixel clock; all state changes on the rising edge
//     reset      in   synchronous, active-high; takes priority over pix_en
//     pix_en     in   advance enable; the position and syncs hold while low
//     hsync      out  horizontal sync, active level SYNC_POL
//     vsync      out  vertical sync, active level SYNC_POL
//     video_on   out  high while the position is inside the visible area
//     pix_x      out  current column, 0 .. H_TOTAL-1 (registered)
//     pix_y      out  current row,    0 .. V_TOTAL-1 (registered)
//     frame_tick out  one-cycle pulse while (0,0) is first presented
// -----------------------------------------------------------------------------
module vga_sync_800x600 #(
   parameter int unsigned H_DISPLAY = 800,
   parameter int unsigned H_FRONT   = 56,
   parameter int unsigned H_SYNC    = 120,
   parameter int unsigned H_BACK    = 64,
   parameter int unsigned V_DISPLAY = 600,
   parameter int unsigned V_FRONT   = 37,
   parameter int unsigned V_SYNC    = 6,
   parameter int unsigned V_BACK    = 23,
   parameter bit          SYNC_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        frame_tick
);

   localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] HLast      = 11'(HTotal - 1);
   localparam logic [10:0] VLast      = 11'(VTotal - 1);
   localparam logic [10:0] HDisp      = 11'(H_DISPLAY);
   localparam logic [10:0] VDisp      = 11'(V_DISPLAY);
   localparam logic [10:0] HSyncStart = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HSyncEnd   = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] VSyncStart = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VSyncEnd   = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        tick_q, tick_d;
   logic        x_wrap, y_wrap;

   // The ">=" compares keep the counters inside the frame even if they were
   // ever pushed out of range; in normal operation they only ever hit "==".
   assign x_wrap = (x_q >= HLast);
   assign y_wrap = (y_q >= VLast);

   // Next position.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_en) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = y_wrap ? '0 : y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
         end
      end
   end

   // Syncs are decoded from the next position and registered, so they change
   // on the same edge as pix_x/pix_y and never glitch. When pix_en is low the
   // next position equals the current one, so the syncs hold as well.
   always_comb begin
      hsync_d = ((x_d >= HSyncStart) && (x_d <= HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((y_d >= VSyncStart) && (y_d <= VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      tick_d  = pix_en && x_wrap && y_wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         // Arm the tick so the (0,0) presented right after release is marked
         // as a frame start.
         tick_q  <= 1'b1;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         tick_q  <= tick_d;
      end
   end

   assign pix_x    = x_q;
   assign pix_y    = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = (x_q < HDisp) && (y_q < VDisp);
   // The armed tick is masked while reset is still held, so frame_tick stays
   // low during reset and shows for the one cycle after release.
   assign frame_tick = tick_q & ~reset;

endmodule

// File: doc/vga_sync_800x600.md
VGA_SYNC_800X600 -- requirements
Module: vga_sync_800x600

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 56, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 120, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 64, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_DISPLAY, default 600, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 37, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 1, active level of hsync/vsync.
REQ-010 SHALL have port clk, input, 1, single pixel clock (50 MHz for defaults); all logic on rising edge.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port pix_en, input, 1, advance enable; counters hold when low.
REQ-013 SHALL have port hsync, output, 1, horizontal sync.
REQ-014 SHALL have port vsync, output, 1, vertical sync.
REQ-015 SHALL have port video_on, output, 1, high inside the visible area.
REQ-016 SHALL have port pix_x, output, 11, current column, feeds downstream object generators.
REQ-017 SHALL have port pix_y, output, 11, current row.
REQ-018 SHALL have port frame_tick, output, 1, one-cycle pulse at frame start.

Function
REQ-019 SHALL keep H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (1040) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (666).
REQ-020 SHALL drive pix_x/pix_y directly from registered counters; all outputs SHALL be glitch-free registered or decoded from registers only.
REQ-021 SHALL, on a clk edge with pix_en=1, increment pix_x; when pix_x = H_TOTAL-1 it SHALL wrap to 0 and pix_y SHALL increment.
REQ-022 SHALL wrap pix_y from V_TOTAL-1 to 0 on the same edge pix_x wraps from H_TOTAL-1.
REQ-023 SHALL hold pix_x, pix_y, hsync, vsync and frame_tick=0 on any edge with pix_en=0.
REQ-024 SHALL assert hsync = SYNC_POL exactly while H_DISPLAY+H_FRONT <= pix_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (856..975), aligned in the same cycle as pix_x.
REQ-025 SHALL assert vsync = SYNC_POL exactly while V_DISPLAY+V_FRONT <= pix_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (637..642), same-cycle aligned with pix_y.
REQ-026 SHALL drive video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY), same cycle.
REQ-027 SHALL pulse frame_tick high for exactly one cycle when pix_x=0 and pix_y=0 are first presented after a wrap or reset release.
REQ-028 SHALL never present pix_x >= H_TOTAL or pix_y >= V_TOTAL.

Reset
REQ-029 SHALL, while reset=1 at a clk edge, load pix_x=0, pix_y=0, hsync=vsync=~SYNC_POL, frame_tick=0; reset SHALL take priority over pix_en.
REQ-030 SHALL, after reset mid-frame, restart the frame at (0,0) with no partial sync pulse carried over.

Verification
REQ-031 Reset asserted 3 cycles -> pix_x=0, pix_y=0, hsync=0, vsync=0, video_on=1, frame_tick=0.
REQ-032 Run pix_en=1 one full line from (0,5) -> hsync high for exactly 120 cycles, pix_x 856..975; at (1039,5) next cycle is (0,6).
REQ-033 Run to (1039,665) -> next cycle (0,0), frame_tick=1 for one cycle only; total frame period 692640 cycles.
REQ-034 Full frame -> vsync high for lines 637..642 only (6x1040 cycles); video_on low at pix_x=800 and pix_y=600.
REQ-035 pix_en low for 10 cycles at (500,300) -> all outputs frozen, frame_tick=0; resumes at (501,300).
REQ-036 Reset pulsed at (900,640) with hsync/vsync active -> next cycle (0,0), both syncs inactive.
